// File: rtl/vga_sync_gen_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 Hz default raster constants and position width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int POS_W = 10;
    localparam int FC_W  = 8;

    localparam int DEF_H_VIEW  = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_H_TOTAL = DEF_H_VIEW + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_VIEW  = 480;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_V_TOTAL = DEF_V_VIEW + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

endpackage

`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Raster timing bundle between the generator and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic               en;
    logic [POS_W-1:0]   hpos;
    logic [POS_W-1:0]   vpos;
    logic               hsync_n;
    logic               vsync_n;
    logic               visible;
    logic               line_end;
    logic               frame_end;
    logic [FC_W-1:0]    frame_count;

    modport master (
        input  en,
        output hpos, vpos, hsync_n, vsync_n, visible, line_end, frame_end, frame_count
    );

    modport slave (
        output en,
        input  hpos, vpos, hsync_n, vsync_n, visible, line_end, frame_end, frame_count
    );

endinterface

`default_nettype wire

// File: rtl/vga_sync_gen_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: wrapping position counter with sync decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VIEW  = DEF_H_VIEW,
    parameter int FRONT = DEF_H_FRONT,
    parameter int SYNC  = DEF_H_SYNC,
    parameter int BACK  = DEF_H_BACK
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 i_step,
    output logic [POS_W-1:0]    o_pos,
    output logic                o_sync_n,
    output logic                o_wrap,
    output logic                o_view_nxt,
    output logic                o_last_nxt
);

    localparam int c_TOTAL      = VIEW + FRONT + SYNC + BACK;
    localparam int c_SYNC_START = VIEW + FRONT;
    localparam int c_SYNC_END   = VIEW + FRONT + SYNC - 1;

    localparam logic [POS_W-1:0] c_LAST   = POS_W'(c_TOTAL - 1);
    localparam logic [POS_W-1:0] c_VIEW   = POS_W'(VIEW);
    localparam logic [POS_W-1:0] c_SSTART = POS_W'(c_SYNC_START);
    localparam logic [POS_W-1:0] c_SEND   = POS_W'(c_SYNC_END);

    logic               w_at_last;
    logic [POS_W-1:0]   w_pos_nxt;
    logic               w_sync_n_nxt;

    assign w_at_last = (o_pos == c_LAST);
    assign o_wrap    = i_step & w_at_last;

    always_comb begin
        w_pos_nxt = o_pos;
        if (i_step) begin
            w_pos_nxt = w_at_last ? '0 : o_pos + 1'b1;
        end
    end

    // Flags are decoded from the next position so they register alongside it.
    assign w_sync_n_nxt = !((w_pos_nxt >= c_SSTART) && (w_pos_nxt <= c_SEND));
    assign o_view_nxt   = (w_pos_nxt < c_VIEW);
    assign o_last_nxt   = (w_pos_nxt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_pos    <= '0;
            o_sync_n <= 1'b1;
        end else begin
            o_pos    <= w_pos_nxt;
            o_sync_n <= w_sync_n_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : Free-running VGA raster timing generator, registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIEW  = DEF_H_VIEW,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int V_VIEW  = DEF_V_VIEW,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK
) (
    input  wire             clk,
    input  wire             reset,
    vga_sync_gen_if.master  bus
);

    logic [POS_W-1:0]   w_hpos;
    logic [POS_W-1:0]   w_vpos;
    logic               w_hsync_n;
    logic               w_vsync_n;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_v_step;
    logic               w_h_view_nxt;
    logic               w_v_view_nxt;
    logic               w_h_last_nxt;
    logic               w_v_last_nxt;

    logic               r_visible;
    logic               r_line_end;
    logic               r_frame_end;
    logic [FC_W-1:0]    r_frame_count;

    assign w_v_step = bus.en & w_h_wrap;

    vga_axis_counter #(
        .VIEW   (H_VIEW),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk        (clk),
        .rst        (reset),
        .i_step     (bus.en),
        .o_pos      (w_hpos),
        .o_sync_n   (w_hsync_n),
        .o_wrap     (w_h_wrap),
        .o_view_nxt (w_h_view_nxt),
        .o_last_nxt (w_h_last_nxt)
    );

    vga_axis_counter #(
        .VIEW   (V_VIEW),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk        (clk),
        .rst        (reset),
        .i_step     (w_v_step),
        .o_pos      (w_vpos),
        .o_sync_n   (w_vsync_n),
        .o_wrap     (w_v_wrap),
        .o_view_nxt (w_v_view_nxt),
        .o_last_nxt (w_v_last_nxt)
    );

    // v wrap only fires while h wraps, so it marks the end of a whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_visible     <= 1'b1;
            r_line_end    <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_visible   <= w_h_view_nxt & w_v_view_nxt;
            r_line_end  <= w_h_last_nxt;
            r_frame_end <= w_h_last_nxt & w_v_last_nxt;
            if (w_v_wrap) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    assign bus.hpos        = w_hpos;
    assign bus.vpos        = w_vpos;
    assign bus.hsync_n     = w_hsync_n;
    assign bus.vsync_n     = w_vsync_n;
    assign bus.visible     = r_visible;
    assign bus.line_end    = r_line_end;
    assign bus.frame_end   = r_frame_end;
    assign bus.frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench: full-size and shrunk-timing instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    // Shrunk raster so vertical sync and frame_count wrap are reachable.
    localparam int SH_V = 8, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int SV_V = 6, SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int S_FRAME = (SH_V + SH_F + SH_S + SH_B) * (SV_V + SV_F + SV_S + SV_B);

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    longint t_model;

    vga_sync_gen_if bus_d ();
    vga_sync_gen_if bus_s ();

    vga_sync_gen u_dut_d (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_d.master)
    );

    vga_sync_gen #(
        .H_VIEW (SH_V), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
        .V_VIEW (SV_V), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B)
    ) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int h; int v; bit hs_n; bit vs_n; bit vis; bit le; bit fe; int fc;
    } exp_t;

    // Raster state derived directly from the count of enabled cycles since reset.
    function automatic exp_t model(longint t, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb);
        exp_t   e;
        int     ht = hv + hf + hs + hb;
        int     vt = vv + vf + vs + vb;
        e.h    = int'(t % ht);
        e.v    = int'((t / ht) % vt);
        e.fc   = int'((t / (ht * vt)) % 256);
        e.hs_n = !(e.h >= hv + hf && e.h < hv + hf + hs);
        e.vs_n = !(e.v >= vv + vf && e.v < vv + vf + vs);
        e.vis  = (e.h < hv) && (e.v < vv);
        e.le   = (e.h == ht - 1);
        e.fe   = (e.h == ht - 1) && (e.v == vt - 1);
        return e;
    endfunction

    task automatic check_dut(string nm, exp_t e, int h, int v, bit hs, bit vs,
                             bit vis, bit le, bit fe, int fc);
        checks++;
        if (e.h != h || e.v != v || e.hs_n != hs || e.vs_n != vs || e.vis != vis ||
            e.le != le || e.fe != fe || e.fc != fc) begin
            errors++;
            $display("FAIL %s t=%0d got h=%0d v=%0d hs=%0b vs=%0b vis=%0b le=%0b fe=%0b fc=%0d exp h=%0d v=%0d hs=%0b vs=%0b vis=%0b le=%0b fe=%0b fc=%0d",
                     nm, t_model, h, v, hs, vs, vis, le, fe, fc,
                     e.h, e.v, e.hs_n, e.vs_n, e.vis, e.le, e.fe, e.fc);
        end
    endtask

    task automatic check_both();
        exp_t ed;
        exp_t es;
        ed = model(t_model, 640, 16, 96, 48, 480, 10, 2, 33);
        es = model(t_model, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B);
        check_dut("full", ed, int'(bus_d.hpos), int'(bus_d.vpos), bus_d.hsync_n,
                  bus_d.vsync_n, bus_d.visible, bus_d.line_end, bus_d.frame_end,
                  int'(bus_d.frame_count));
        check_dut("small", es, int'(bus_s.hpos), int'(bus_s.vpos), bus_s.hsync_n,
                  bus_s.vsync_n, bus_s.visible, bus_s.line_end, bus_s.frame_end,
                  int'(bus_s.frame_count));
        if (errors > 60) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    task automatic step(bit r, bit e);
        @(negedge clk);
        reset    = r;
        bus_d.en = e;
        bus_s.en = e;
        @(posedge clk);
        if (r)      t_model = 0;
        else if (e) t_model++;
        #1;
        check_both();
    endtask

    typedef struct {
        bit  rst;
        bit  en;
        int  n;
        int  exp_h;
        int  exp_v;
        bit  exp_le;
        bit  exp_vis;
        bit  exp_hs_n;
    } vec_t;

    vec_t vecs[11];

    initial begin
        checks  = 0;
        errors  = 0;
        t_model = 0;
        reset    = 1'b1;
        bus_d.en = 1'b0;
        bus_s.en = 1'b0;

        vecs[0]  = '{1, 1, 3,   0,   0, 0, 1, 1};  // reset beats enable
        vecs[1]  = '{0, 1, 1,   1,   0, 0, 1, 1};  // one cycle after release
        vecs[2]  = '{0, 1, 638, 639, 0, 0, 1, 1};
        vecs[3]  = '{0, 1, 1,   640, 0, 0, 0, 1};  // visible falls
        vecs[4]  = '{0, 1, 16,  656, 0, 0, 0, 0};  // hsync starts
        vecs[5]  = '{0, 1, 95,  751, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, 1,   752, 0, 0, 0, 1};  // hsync ends
        vecs[7]  = '{0, 1, 47,  799, 0, 1, 0, 1};
        vecs[8]  = '{0, 0, 5,   799, 0, 1, 0, 1};  // frozen, line_end held
        vecs[9]  = '{0, 1, 1,   0,   1, 0, 1, 1};
        vecs[10] = '{0, 1, 300, 300, 1, 0, 1, 1};

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].rst, vecs[i].en);
            checks++;
            if (int'(bus_d.hpos) != vecs[i].exp_h || int'(bus_d.vpos) != vecs[i].exp_v ||
                bus_d.line_end != vecs[i].exp_le || bus_d.visible != vecs[i].exp_vis ||
                bus_d.hsync_n != vecs[i].exp_hs_n) begin
                errors++;
                $display("FAIL vec%0d got h=%0d v=%0d le=%0b vis=%0b hs=%0b exp h=%0d v=%0d le=%0b vis=%0b hs=%0b",
                         i, bus_d.hpos, bus_d.vpos, bus_d.line_end, bus_d.visible, bus_d.hsync_n,
                         vecs[i].exp_h, vecs[i].exp_v, vecs[i].exp_le, vecs[i].exp_vis,
                         vecs[i].exp_hs_n);
            end
        end

        // Mid-line reset held three cycles.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        checks++;
        if (bus_d.hpos != 0 || bus_d.vpos != 0 || bus_d.frame_count != 0 || !bus_d.visible) begin
            errors++;
            $display("FAIL mid_reset got h=%0d v=%0d fc=%0d vis=%0b exp h=0 v=0 fc=0 vis=1",
                     bus_d.hpos, bus_d.vpos, bus_d.frame_count, bus_d.visible);
        end

        // Random enable gating with occasional resets.
        for (int k = 0; k < 8000; k++) begin
            step($urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0);
        end

        // Run the shrunk raster through 256 frames to see frame_count wrap.
        step(1'b1, 1'b0);
        for (int k = 0; k < 255 * S_FRAME; k++) step(1'b0, 1'b1);
        checks++;
        if (bus_s.frame_count != 8'd255 || bus_s.hpos != 0 || bus_s.vpos != 0) begin
            errors++;
            $display("FAIL fc_255 got fc=%0d h=%0d v=%0d exp fc=255 h=0 v=0",
                     bus_s.frame_count, bus_s.hpos, bus_s.vpos);
        end
        for (int k = 0; k < S_FRAME - 1; k++) step(1'b0, 1'b1);
        checks++;
        if (!bus_s.frame_end || bus_s.frame_count != 8'd255) begin
            errors++;
            $display("FAIL fe_last got fe=%0b fc=%0d exp fe=1 fc=255",
                     bus_s.frame_end, bus_s.frame_count);
        end
        step(1'b0, 1'b1);
        checks++;
        if (bus_s.frame_count != 8'd0 || bus_s.frame_end || bus_s.hpos != 0 || bus_s.vpos != 0) begin
            errors++;
            $display("FAIL fc_wrap got fc=%0d fe=%0b h=%0d v=%0d exp fc=0 fe=0 h=0 v=0",
                     bus_s.frame_count, bus_s.frame_end, bus_s.hpos, bus_s.vpos);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
